// File: rtl/mem_access_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_seq_pkg
//  Purpose  : Shared definitions for the memory access sequencer. This covers
//             the access size encodings, the FSM state encoding, the width of
//             the read-latency counter, and a size normalisation helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_seq_pkg;

  // Access size encodings; 2'b11 is treated as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Sequencer states, kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Read-latency counter width. It covers MEM_LATENCY up to 7.
  localparam int CNT_W = 3;

  // Fold the reserved encoding 2'b11 onto a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_seq_ls.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_seq_ls
//  Purpose  : Load-size unit. It zero-extends the selected low byte or
//             halfword of a memory word, or passes the whole word through.
//  Ports    : ls_control  in  2   access size (SIZE_*)
//             mdr         in  32  memory data word
//             load_data   out 32  zero-extended load result
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_seq_ls
  import mem_access_seq_pkg::*;
(
  input  logic [1:0]  ls_control,
  input  logic [31:0] mdr,
  output logic [31:0] load_data
);

  always_comb begin
    load_data = mdr;
    case (ls_control)
      SIZE_BYTE: load_data = {24'h0, mdr[7:0]};
      SIZE_HALF: load_data = {16'h0, mdr[15:0]};
      default:   load_data = mdr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_seq_ss.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_seq_ss
//  Purpose  : Store-size unit. It merges the low byte or halfword of the
//             store operand into the existing memory word. Word stores pass
//             the operand through unchanged.
//  Ports    : ss_control  in  2   access size (SIZE_*)
//             mdr         in  32  existing memory word
//             b           in  32  store operand (RegB)
//             merged      out 32  word to write back
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_seq_ss
  import mem_access_seq_pkg::*;
(
  input  logic [1:0]  ss_control,
  input  logic [31:0] mdr,
  input  logic [31:0] b,
  output logic [31:0] merged
);

  always_comb begin
    merged = b;
    case (ss_control)
      SIZE_BYTE: merged = {mdr[31:8],  b[7:0]};
      SIZE_HALF: merged = {mdr[31:16], b[15:0]};
      default:   merged = b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_seq
//  Purpose  : Memory-side access sequencer. It accepts one load or store
//             request and runs the corresponding memory transaction:
//               load           : READ -> DONE
//               sub-word store : READ -> WRITE -> DONE (read-merge-write)
//               word store     : WRITE -> DONE (no read)
//  Ports    : clk         in  1   clock, rising edge
//             reset       in  1   asynchronous active-low reset
//             Start       in  1   request strobe, sampled only in IDLE
//             IsStore     in  1   1 = store, 0 = load
//             Size        in  2   00 byte, 01 half, 10/11 word
//             Address     in  32  word address
//             StoreData   in  32  store operand (RegB)
//             MemDataIn   in  32  memory read data
//             MemAddr     out 32  latched request address
//             MemWr       out 1   memory write enable
//             MemDataOut  out 32  registered write data
//             LoadData    out 32  zero-extended load result
//             Busy        out 1   high outside IDLE
//             Done        out 1   one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataOut,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mdr;
  logic               is_store;
  logic [1:0]         size;
  logic [31:0]        store_data;

  logic               read_last;
  logic               start_word_store;
  logic [31:0]        mdr_next;
  logic [31:0]        extract;
  logic [31:0]        merge;

  assign read_last        = (state == ST_READ) && (cnt == CNT_LAST);
  assign start_word_store = IsStore && (norm_size(Size) == SIZE_WORD);

  // The load result and write-back word are registered on the same edge that
  // captures MDR. The size units therefore see the value MDR is about to
  // take, not its current contents.
  assign mdr_next = read_last ? MemDataIn : mdr;

  mem_access_seq_ls u_ls (
    .ls_control (size),
    .mdr        (mdr_next),
    .load_data  (extract)
  );

  mem_access_seq_ss u_ss (
    .ss_control (size),
    .mdr        (mdr_next),
    .b          (store_data),
    .merged     (merge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mdr        <= '0;
      is_store   <= 1'b0;
      size       <= SIZE_BYTE;
      store_data <= '0;
      MemAddr    <= '0;
      MemDataOut <= '0;
      LoadData   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            is_store   <= IsStore;
            size       <= norm_size(Size);
            MemAddr    <= Address;
            store_data <= StoreData;
            cnt        <= '0;
            if (start_word_store) begin
              // A full-word store needs no read, so the operand goes straight out.
              MemDataOut <= StoreData;
              state      <= ST_WRITE;
            end else begin
              state      <= ST_READ;
            end
          end
        end
        ST_READ: begin
          cnt <= cnt + 1'b1;
          if (read_last) begin
            mdr <= MemDataIn;
            if (is_store) begin
              MemDataOut <= merge;
              state      <= ST_WRITE;
            end else begin
              LoadData   <= extract;
              state      <= ST_DONE;
            end
          end
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register, so an async reset drops these at once.
  assign MemWr = (state == ST_WRITE);
  assign Done  = (state == ST_DONE);
  assign Busy  = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_seq
//  Purpose  : Directed self-checking bench for mem_access_seq. It uses one
//             instance with MEM_LATENCY=1 and one with MEM_LATENCY=3, which
//             share all request inputs but have separate Start strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic        is_store;
  logic [1:0]  size;
  logic [31:0] address, store_data, mem_data_in;

  logic [31:0] d1_addr, d1_dout, d1_load;
  logic        d1_wr, d1_busy, d1_done;
  logic [31:0] d3_addr, d3_dout, d3_load;
  logic        d3_wr, d3_busy, d3_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_access_seq #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .Start(start1), .IsStore(is_store), .Size(size),
    .Address(address), .StoreData(store_data), .MemDataIn(mem_data_in),
    .MemAddr(d1_addr), .MemWr(d1_wr), .MemDataOut(d1_dout), .LoadData(d1_load),
    .Busy(d1_busy), .Done(d1_done)
  );

  mem_access_seq #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .Start(start3), .IsStore(is_store), .Size(size),
    .Address(address), .StoreData(store_data), .MemDataIn(mem_data_in),
    .MemAddr(d3_addr), .MemWr(d3_wr), .MemDataOut(d3_dout), .LoadData(d3_load),
    .Busy(d3_busy), .Done(d3_done)
  );

  // Set up a request. It is sampled at the next rising edge (edge N). On
  // return we are just past edge N with Start already dropped.
  task automatic issue(input bit use3, input bit st, input logic [1:0] sz,
                       input logic [31:0] adr, input logic [31:0] b);
    is_store = st; size = sz; address = adr; store_data = b;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start3 = 1'b0;
    // Scramble the request inputs; the DUT must rely on its latched copies.
    is_store = ~st; size = ~sz; address = 32'hDEAD_BEEF; store_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    is_store = 1'b0; size = 2'b00; address = '0; store_data = '0; mem_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({d1_addr, d1_dout, d1_load, d1_wr, d1_busy, d1_done} !== 99'h0) begin
      $display("FAIL reset_dut1 got addr=%h dout=%h load=%h wr/busy/done=%b%b%b expected all 0",
               d1_addr, d1_dout, d1_load, d1_wr, d1_busy, d1_done);
    end else pass_cnt++;
    total_cnt++;
    if ({d3_addr, d3_dout, d3_load, d3_wr, d3_busy, d3_done} !== 99'h0) begin
      $display("FAIL reset_dut3 got addr=%h dout=%h load=%h wr/busy/done=%b%b%b expected all 0",
               d3_addr, d3_dout, d3_load, d3_wr, d3_busy, d3_done);
    end else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Byte load with L=1: Done in N+2, idle in N+3, never writes.
  task automatic test_load_byte();
    logic [2:0] exp;
    mem_data_in = 32'hAABBCCDD;
    issue(1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      exp = {(k <= 2) ? 1'b1 : 1'b0, (k == 2) ? 1'b1 : 1'b0, 1'b0};
      total_cnt++;
      if ({d1_busy, d1_done, d1_wr} !== exp) begin
        $display("FAIL load_byte_ctrl cycle N+%0d got busy/done/wr=%b expected %b",
                 k, {d1_busy, d1_done, d1_wr}, exp);
      end else pass_cnt++;
      if (k == 2) begin
        total_cnt++;
        if (d1_load !== 32'h0000_00DD) begin
          $display("FAIL load_byte_data got %h expected 000000dd", d1_load);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (d1_addr !== 32'h0000_0040) begin
      $display("FAIL load_byte_addr got %h expected 00000040", d1_addr);
    end else pass_cnt++;
  endtask

  // Halfword load with L=3: Busy during N+1..N+4 and Done in N+4.
  task automatic test_load_half();
    logic [2:0] exp;
    mem_data_in = 32'hAABBCCDD;
    issue(1'b1, 1'b0, 2'b01, 32'h0000_0080, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = {(k <= 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0, 1'b0};
      total_cnt++;
      if ({d3_busy, d3_done, d3_wr} !== exp) begin
        $display("FAIL load_half_ctrl cycle N+%0d got busy/done/wr=%b expected %b",
                 k, {d3_busy, d3_done, d3_wr}, exp);
      end else pass_cnt++;
    end
    total_cnt++;
    if (d3_load !== 32'h0000_CCDD) begin
      $display("FAIL load_half_data got %h expected 0000ccdd", d3_load);
    end else pass_cnt++;
  endtask

  // Sub-word stores with L=1: READ N+1, WRITE N+2, Done N+3.
  task automatic test_store_subword();
    logic [2:0]  exp;
    logic [31:0] exp_data [2];
    exp_data[0] = 32'hAABBCC78;
    exp_data[1] = 32'hAABB5678;
    mem_data_in = 32'hAABBCCDD;
    for (int s = 0; s < 2; s++) begin
      issue(1'b0, 1'b1, 2'(s), 32'h0000_0100, 32'h12345678);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        exp = {(k <= 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0, (k == 2) ? 1'b1 : 1'b0};
        total_cnt++;
        if ({d1_busy, d1_done, d1_wr} !== exp) begin
          $display("FAIL store_sub%0d_ctrl cycle N+%0d got busy/done/wr=%b expected %b",
                   s, k, {d1_busy, d1_done, d1_wr}, exp);
        end else pass_cnt++;
        if (k == 2) begin
          total_cnt++;
          if (d1_dout !== exp_data[s]) begin
            $display("FAIL store_sub%0d_data got %h expected %h", s, d1_dout, exp_data[s]);
          end else pass_cnt++;
        end
      end
    end
  endtask

  // Word store on the L=3 instance skips READ: WRITE N+1, Done N+2.
  task automatic test_store_word();
    logic [2:0] exp;
    mem_data_in = 32'h0;
    issue(1'b1, 1'b1, 2'b10, 32'h0000_0200, 32'hFFFFFFFF);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      exp = {(k <= 2) ? 1'b1 : 1'b0, (k == 2) ? 1'b1 : 1'b0, (k == 1) ? 1'b1 : 1'b0};
      total_cnt++;
      if ({d3_busy, d3_done, d3_wr} !== exp) begin
        $display("FAIL store_word_ctrl cycle N+%0d got busy/done/wr=%b expected %b",
                 k, {d3_busy, d3_done, d3_wr}, exp);
      end else pass_cnt++;
      if (k == 1) begin
        total_cnt++;
        if (d3_dout !== 32'hFFFFFFFF) begin
          $display("FAIL store_word_data got %h expected ffffffff", d3_dout);
        end else pass_cnt++;
      end
    end
  endtask

  // Start pulsed during READ with a new address must be dropped entirely.
  task automatic test_start_while_busy();
    int dones = 0;
    mem_data_in = 32'h0BAD_F00D;
    issue(1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (d3_done) dones++;
      if (k == 1) begin
        start3 = 1'b1; address = 32'h0000_0200; is_store = 1'b0;
      end else if (k == 2) begin
        start3 = 1'b0;
      end
      if (k == 3) begin
        total_cnt++;
        if (d3_addr !== 32'h0000_0100) begin
          $display("FAIL busy_start_addr got %h expected 00000100", d3_addr);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (dones != 1) $display("FAIL busy_start_dones got %0d expected 1", dones);
    else pass_cnt++;
    total_cnt++;
    if ({d3_busy, d3_addr} !== {1'b0, 32'h0000_0100}) begin
      $display("FAIL busy_start_final got busy=%b addr=%h expected busy=0 addr=00000100",
               d3_busy, d3_addr);
    end else pass_cnt++;
  endtask

  // Reset during WRITE clears outputs without a clock edge. A later size-11
  // load then completes as a word load.
  task automatic test_reset_mid_write();
    mem_data_in = 32'hAABBCCDD;
    issue(1'b0, 1'b1, 2'b00, 32'h0000_0300, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (d1_wr !== 1'b1) $display("FAIL rst_write_entry got wr=%b expected 1", d1_wr);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({d1_wr, d1_done, d1_busy} !== 3'b000) begin
      $display("FAIL rst_async_ctrl got wr/done/busy=%b expected 000", {d1_wr, d1_done, d1_busy});
    end else pass_cnt++;
    total_cnt++;
    if ({d1_addr, d1_dout, d1_load} !== 96'h0) begin
      $display("FAIL rst_async_data got addr=%h dout=%h load=%h expected all 0",
               d1_addr, d1_dout, d1_load);
    end else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_data_in = 32'h13572468;
    issue(1'b0, 1'b0, 2'b11, 32'h0000_0044, 32'h0);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({d1_done, d1_wr, d1_load} !== {1'b1, 1'b0, 32'h13572468}) begin
      $display("FAIL rst_recover_load got done=%b wr=%b load=%h expected done=1 wr=0 load=13572468",
               d1_done, d1_wr, d1_load);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (d1_busy !== 1'b0) $display("FAIL rst_recover_idle got busy=%b expected 0", d1_busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_subword();
    test_store_word();
    test_start_while_busy();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_seq.md
# mem_access_seq

Memory-side access sequencer for the multicycle datapath: accepts one load or store request from the control unit and runs the memory transaction. Loads read the word at Address, capture it into an internal MDR, and return the size-extracted value. Sub-word stores read, merge, then write back. Word stores write directly without a read. It is the memory-facing counterpart of the LS/SS size units and reuses them internally.

## Interface
- MEM_LATENCY, 1, read cycles between address presentation and valid MemDataIn; legal range 1..7.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- IsStore  in  1  1 = store, 0 = load; latched with Start.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word; latched with Start.
- Address  in  32  word address; latched with Start.
- StoreData  in  32  RegB value; latched with Start.
- MemDataIn  in  32  memory read data.
- MemAddr  out  32  latched request address.
- MemWr  out  1  memory write enable.
- MemDataOut  out  32  registered write data.
- LoadData  out  32  zero-extended load result; holds until the next load completes.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with Start=1 latches IsStore, Size, Address and StoreData.
  - Word store: go to WRITE.
  - All other requests: go to READ with cycle counter = 0.
- READ: MemWr=0.
  - Counter increments each cycle.
  - On the last cycle (counter = MEM_LATENCY-1), MDR <= MemDataIn.
  - Next state: DONE for a load, WRITE for a sub-word store.
- WRITE: MemWr=1 for exactly one cycle; next state DONE.
- DONE: Done=1 for exactly one cycle; next state IDLE.
- Load extract (zero-extend from MDR):
  - byte: {24'h0, MDR[7:0]}
  - half: {16'h0, MDR[15:0]}
  - word: MDR
  - LoadData is registered on the READ→DONE transition.
- Store merge, registered into MemDataOut on entry to WRITE:
  - byte: {MDR[31:8], B[7:0]}
  - half: {MDR[31:16], B[15:0]}
  - word: B, with no read.
- Start while Busy=1 is ignored; it is neither queued nor latched.
- Inputs may change freely after the Start cycle.

## Timing
- Reset values: state IDLE; MemAddr, MemDataOut, LoadData, MDR and counter = 0; MemWr, Busy, Done = 0.
- Reset asserted mid-operation drops MemWr and Done immediately (async) and returns to IDLE. No partial write is reissued.
- Start sampled at edge N gives:
  - Word store: WRITE in cycle N+1, Done in N+2, IDLE in N+3.
  - Load: READ in cycles N+1..N+L, Done with LoadData valid in N+L+1.
  - Sub-word store: READ in N+1..N+L, WRITE in N+L+1, Done in N+L+2.
- L = MEM_LATENCY.
- MemAddr is stable from N+1 until the next accepted Start.
- MemDataOut is stable throughout WRITE.
- Back-to-back operation: Start may be reasserted during DONE, but it is sampled only in the following IDLE cycle. The minimum request spacing is therefore the full sequence plus one IDLE cycle.

## Structure
- Shared package holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - state enum (IDLE/READ/WRITE/DONE);
  - counter width constant (3 bits).
- Instantiate the existing ls and ss units for extract and merge. LSControl and RegSSControl are driven from the latched Size with 11 mapped to 10.
- Single FSM plus datapath registers; no further sub-modules.

## Test plan
- Load byte, L=1, MemDataIn=0xAABBCCDD: Start at edge N → Done in N+2, LoadData=0x000000DD; MemWr never high.
- Load halfword, L=3, MemDataIn=0xAABBCCDD: Done in N+4, LoadData=0x0000CCDD; Busy high for cycles N+1..N+4.
- Store byte, L=1, StoreData=0x12345678, memory word=0xAABBCCDD: one MemWr cycle in N+2 with MemDataOut=0xAABBCC78, Done in N+3. Repeat for halfword → 0xAABB5678.
- Store word, StoreData=0xFFFFFFFF: no READ state, MemWr high in N+1 with MemDataOut=0xFFFFFFFF, Done in N+2.
- Start pulsed again during READ with different Address: ignored, MemAddr unchanged, exactly one Done.
- Reset low during WRITE: MemWr falls without a clock edge, all outputs return to 0; a fresh load after release completes normally.
